// File: rtl/game_pkg.sv
// Shared keeper-side definitions: position-TX state encoding, tag base and the
// default byte/tag widths also used by the receiver-side decoder.
package game_pkg;

  localparam int POS_DATA_W          = 8;
  localparam int POS_TAG_W           = 3;
  localparam int KEEPER_POS_TAG_BASE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SEND = 2'd2,
    HOLD = 2'd3
  } pos_tx_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/keeper_pos_tx_if.sv
// Position packetiser bus: control/position inputs and the UART FIFO write side.
// master = packetiser, slave = surrounding logic / FIFO.
interface keeper_pos_tx_if import game_pkg::*; #(
  parameter int DATA_W = POS_DATA_W,
  parameter int POS_W  = 10,
  parameter int N_CH   = 2
);
  logic                     enable;
  logic [N_CH*POS_W-1:0]    pos;
  logic                     tx_full;
  logic                     wr_uart;
  logic [DATA_W-1:0]        w_data;
  logic                     busy;
  logic                     frame_done;

  modport master (
    input  enable, pos, tx_full,
    output wr_uart, w_data, busy, frame_done
  );

  modport slave (
    output enable, pos, tx_full,
    input  wr_uart, w_data, busy, frame_done
  );
endinterface

// File: rtl/keeper_pos_tx_refresh_tick_gen.sv
// Wrap counter 0..CYCLES-1 with synchronous restart; tick is high for the one
// cycle the counter sits at its final value.
module refresh_tick_gen #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (restart || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST) && !restart;
endmodule

// File: rtl/keeper_pos_tx.sv
// Send-on-change position packetiser: N_CH channels -> tagged UART bytes.
// Optional periodic resend enabled by defining KEEPER_POS_TX_REFRESH_EN.
module keeper_pos_tx import game_pkg::*; #(
  parameter int DATA_W         = POS_DATA_W,
  parameter int TAG_W          = POS_TAG_W,
  parameter int POS_W          = 10,
  parameter int N_CH           = 2,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  keeper_pos_tx_if.master  bus
);
  localparam int CHUNK_W = DATA_W - TAG_W;
  localparam int CHUNKS  = ceil_div(POS_W, CHUNK_W);
  localparam int N_BYTES = N_CH * CHUNKS;
  localparam int PAD_W   = CHUNKS * CHUNK_W;
  localparam int N_SLOTS = 2 ** TAG_W;

  if (N_BYTES > N_SLOTS - 1) begin : g_tag_overflow
    $error("keeper_pos_tx: N_CH*CHUNKS exceeds the tag space");
  end
  if (REFRESH_CYCLES < 1) begin : g_bad_refresh
    $error("keeper_pos_tx: REFRESH_CYCLES must be at least 1");
  end

  pos_tx_state_t            state_reg;
  logic [N_CH*POS_W-1:0]    snap_reg;
  logic [N_CH*POS_W-1:0]    last_sent_reg;
  logic [TAG_W-1:0]         cnt_reg;
  logic                     wr_uart_reg;
  logic [DATA_W-1:0]        w_data_reg;
  logic                     frame_done_reg;
  logic                     refresh_go;

  // Every channel zero-padded to a whole number of chunks, laid out in send order.
  logic [N_BYTES*CHUNK_W-1:0] pad_all;
  logic [CHUNK_W-1:0]         chunk_arr [N_SLOTS];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_pad
    assign pad_all[gi*PAD_W +: PAD_W] = PAD_W'(snap_reg[gi*POS_W +: POS_W]);
  end

  // Table sized to the full tag space so the byte counter indexes it directly.
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_chunk
    if (gi < N_BYTES) begin : g_used
      assign chunk_arr[gi] = pad_all[gi*CHUNK_W +: CHUNK_W];
    end else begin : g_unused
      assign chunk_arr[gi] = '0;
    end
  end

  logic [TAG_W-1:0]  cur_tag;
  logic [DATA_W-1:0] cur_byte;
  assign cur_tag  = TAG_W'(KEEPER_POS_TAG_BASE) + cnt_reg;
  assign cur_byte = {chunk_arr[cnt_reg], cur_tag};

`ifdef KEEPER_POS_TX_REFRESH_EN
  logic refresh_tick;
  logic refresh_pend_reg;

  refresh_tick_gen #(
    .CYCLES (REFRESH_CYCLES)
  ) u_refresh (
    .clk     (clk),
    .rst     (rst),
    .restart (state_reg == SNAP),
    .tick    (refresh_tick)
  );

  // A tick seen mid-frame is remembered until the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_pend_reg <= 1'b0;
    end else if (state_reg == SNAP) begin
      refresh_pend_reg <= 1'b0;
    end else if (refresh_tick) begin
      refresh_pend_reg <= 1'b1;
    end
  end

  assign refresh_go = refresh_tick | refresh_pend_reg;
`else
  assign refresh_go = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      snap_reg       <= '0;
      last_sent_reg  <= '0;
      cnt_reg        <= '0;
      wr_uart_reg    <= 1'b0;
      w_data_reg     <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      wr_uart_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.enable && ((bus.pos != last_sent_reg) || refresh_go)) begin
            state_reg <= SNAP;
          end
        end
        SNAP: begin
          snap_reg  <= bus.pos;
          cnt_reg   <= '0;
          state_reg <= SEND;
        end
        SEND: begin
          // Losing enable abandons the frame; last_sent is untouched so it resends whole.
          if (!bus.enable) begin
            state_reg <= IDLE;
          end else if (!bus.tx_full) begin
            wr_uart_reg <= 1'b1;
            w_data_reg  <= cur_byte;
            cnt_reg     <= cnt_reg + 1'b1;
            state_reg   <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_reg == TAG_W'(N_BYTES)) begin
            last_sent_reg  <= snap_reg;
            frame_done_reg <= 1'b1;
            state_reg      <= IDLE;
          end else begin
            state_reg <= SEND;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.wr_uart    = wr_uart_reg;
  assign bus.w_data     = w_data_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.busy       = (state_reg != IDLE);
endmodule
